ms_delay_sched: RTL and testbench
=================================

# ms_delay_sched

Shared millisecond delay scheduler for the G-15 simulation peripherals: several requesters (typewriter, photo-reader, punch, etc.) each ask for a delay of a programmable number of milliseconds. The block queues those requests and grants a single shared countdown timer to them round-robin. The timer advances on the system-wide `one_ms` strobe. Each requester gets a one-cycle `done` pulse when its delay has elapsed. This replaces one private delay counter per peripheral with one timer plus a small queue.

## Interface

Parameters:
- `N`, 4 — number of requesters (≥2).
- `W`, 10 — delay-length width in ms; maximum delay is 2^W−1 ms.

Ports:
- `clk` in 1 — system clock.
- `rst_n` in 1 — reset; one clock, asynchronous, active-low.
- `one_ms` in 1 — one-cycle strobe, once per millisecond.
- `req` in N — per-requester one-cycle request pulse.
- `len` in N*W — per-requester delay in ms; slice i is `len[i*W +: W]`, sampled with `req[i]`.
- `busy` out N — requester i is pending or currently timing.
- `done` out N — one-cycle pulse, delay for requester i elapsed.
- `running` out 1 — timer is in RUN or DONE.
- `active` out $clog2(N) — index of the requester owning the timer; holds its last value when idle.

## Operation

Per-requester queue:
- Each requester has `pend[i]` and `plen[i]`.
- On `req[i]` with `pend[i]==0`: set `pend[i]`, latch `plen[i] <= len[i]`.
- `req[i]` while `pend[i]==1` is ignored; the first latched length is kept.
- A requester that currently owns the timer may re-request. It is queued as a new pending entry.

FSM states: IDLE, RUN, DONE.
- **IDLE**, with any `pend` set:
  - The round-robin grant `g` is the first pending index searching from `last+1` mod N.
  - Actions: `ctr <= plen[g]`, `pend[g] <= 0`, `active <= g`, `last <= g`, go to RUN.
  - `one_ms` is ignored in IDLE.
- **RUN**:
  - If `ctr==0`: go to DONE, and `done[active] <= 1` for exactly that cycle.
  - Else if `one_ms`: `ctr <= ctr−1`.
- **DONE**: go to IDLE. There is no re-grant in DONE.

Rules:
- `len==0` is legal: done arrives one cycle after the grant, without waiting for any strobe.
- If `req[i]` and the grant of i occur in the same cycle, the grant wins. The pending bit is cleared and the new request is dropped. This can only happen when `pend[i]` was already set, so the drop is consistent with the ignore rule.
- Reset values: `pend=0`, `plen=0`, `ctr=0`, `state=IDLE`, `last=N−1` (first arbitration favours index 0), `active=0`, `done=0`, `busy=0`, `running=0`.
- Asserting `rst_n` low mid-delay discards all queued and running work. No `done` is issued.
- `busy[i] = pend[i] | (state!=IDLE & active==i)`.
- `busy` and `running` are derived from registers only.

## Timing

- `done` is a registered output.
- Single request from i with length D, reqs in cycle 0:
  - cycle 1: `pend[i]=1`, `busy[i]=1`.
  - cycle 2: RUN, `ctr=D`.
  - After D `one_ms` strobes sampled in RUN, `ctr==0`. The following cycle is DONE with `done[i]=1`; the next cycle is IDLE.
- Elapsed wall time is D ms after the grant, to within one clock. It is not measured from the request.
- Back-to-back service: DONE → IDLE (grant) → RUN. The turnaround between owners is 2 cycles, plus the ms wait.
- `busy[i]` falls in the cycle after `done[i]`, unless i re-requested.
- Worst-case wait for a requester is (N−1) other full delays.

## Structure

- Package `ms_delay_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - Default constants `MS_DELAY_N` and `MS_DELAY_W`.
- Sub-module `rr_arbiter`, parameterized by N:
  - Inputs: request vector and `last` pointer.
  - Outputs: combinational `grant_valid` and `grant_idx`.
  - Reused elsewhere for I/O channel sharing.
- Top level: queue registers, the single W-bit counter and the FSM.

## Test plan

- **Single, D=3:** strobes every 10 cycles, `req[1]`, `len=3` → `done[1]` exactly once, after the 3rd strobe plus 1 cycle. `busy[1]` high from cycle 1 until the cycle after `done`.
- **Zero length:** `req[0]`, `len=0` → `done[0]` at cycle 3 with no strobe. `running` is high in cycles 2–3.
- **Round-robin:** `req` to 0, 2 and 3 in the same cycle, all `len=1`, after a previous grant to 2 → service order 3, 0, 2. Three distinct `done` pulses.
- **Duplicate request:** `req[1]`, `len=5`, then `req[1]`, `len=2` while pending → `done[1]` fires once, after 5 strobes.
- **Re-request while active:** `req[2]` during its own RUN → a second `done[2]` after the first, with `busy[2]` staying high in between.
- **Reset mid-RUN:** `rst_n` low with `ctr=4` and two requests pending → all outputs 0 immediately. No `done` ever follows.

Source files
------------

// File: rtl/ms_delay_sched_pkg.sv
// Shared types and default sizing for the millisecond delay scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ms_delay_pkg;

  localparam int MS_DELAY_N = 4;
  localparam int MS_DELAY_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ms_delay_sched_rr_arbiter.sv
// Round-robin picker: first set request searching upward from last+1 (mod N).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ms_delay_sched.sv
// One shared ms countdown timer handed round-robin to N queued delay requests.
// Latency: grant 1 cycle after pend, done 1 cycle after the counter reaches zero.
// Backpressure: one pending slot per requester; repeats while pending are dropped.
module ms_delay_sched
  import ms_delay_pkg::*;
#(
  parameter int N = MS_DELAY_N,
  parameter int W = MS_DELAY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 one_ms,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       len,
  output logic [N-1:0]         busy,
  output logic [N-1:0]         done,
  output logic                 running,
  output logic [$clog2(N)-1:0] active
);

  localparam int IW = $clog2(N);

  state_t        state;
  logic [N-1:0]  pend;
  logic [W-1:0]  plen [N];
  logic [W-1:0]  ctr;
  logic [IW-1:0] last;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          grant_fire;

  rr_arbiter #(.N(N)) u_arb (
    .req         (pend),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The timer is only handed out from IDLE; DONE always passes through IDLE first.
  assign grant_fire = (state == IDLE) && grant_valid;

  // Per-requester pending slot: the grant clears it, a fresh request fills an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int i = 0; i < N; i++) plen[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant_fire && (grant_idx == IW'(i))) begin
          pend[i] <= 1'b0;
        end else if (req[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          plen[i] <= len[i*W +: W];
        end
      end
    end
  end

  // Timer FSM: load on grant, count strobes while running, pulse done once at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ctr    <= '0;
      last   <= IW'(N - 1);
      active <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            ctr    <= plen[grant_idx];
            active <= grant_idx;
            last   <= grant_idx;
            state  <= RUN;
          end
        end
        RUN: begin
          if (ctr == '0) begin
            done[active] <= 1'b1;
            state        <= DONE;
          end else if (one_ms) begin
            ctr <= ctr - W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags come straight from registers so they are glitch-free for consumers.
  always_comb begin
    busy = pend;
    if (state != IDLE) busy[active] = 1'b1;
  end

  assign running = (state != IDLE);

endmodule

// File: tb/tb_ms_delay_sched.sv
// Bench for ms_delay_sched: service-level model compared every cycle plus literal timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_ms_delay_sched;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           one_ms;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   busy;
  logic [N-1:0]   done;
  logic           running;
  logic [IW-1:0]  active;

  ms_delay_sched #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .one_ms  (one_ms),
    .req     (req),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .running (running),
    .active  (active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Service model: each requester holds at most one waiting delay; the timer
  // has an owner (or none), the strobes it still needs, and a finished flag.
  bit           m_pend [N];
  int           m_plen [N];
  int           m_owner;
  int           m_left;
  bit           m_fin;
  int           m_last;
  int           m_active;
  logic [N-1:0] m_done;
  bit           m_acc  [N];
  int           m_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_plen[i] = 0; end
      m_owner = -1; m_left = 0; m_fin = 0; m_last = N - 1; m_active = 0; m_done = '0;
    end else begin
      for (int i = 0; i < N; i++) m_acc[i] = req[i] && !m_pend[i];
      m_done = '0;
      if (m_owner < 0) begin
        m_g = -1;
        for (int k = 1; k <= N; k++)
          if (m_g < 0 && m_pend[(m_last + k) % N]) m_g = (m_last + k) % N;
        if (m_g >= 0) begin
          m_owner = m_g; m_left = m_plen[m_g]; m_pend[m_g] = 0;
          m_last = m_g; m_active = m_g;
        end
      end else if (m_fin) begin
        m_owner = -1; m_fin = 0;
      end else if (m_left == 0) begin
        m_fin = 1; m_done[m_owner] = 1'b1;
      end else if (one_ms) begin
        m_left = m_left - 1;
      end
      for (int i = 0; i < N; i++)
        if (m_acc[i]) begin m_pend[i] = 1; m_plen[i] = int'(len[i*W +: W]); end
    end
  end

  // Done log and busy[2] watch window used by the literal checks.
  int dlog_cyc [$];
  int dlog_idx [$];
  int w_lo = -1, w_hi = -2, b2_low = 0;
  logic [N-1:0] eb;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < N; i++) eb[i] = m_pend[i] || (m_owner == i);
      chk("busy",    int'(busy),    int'(eb));
      chk("done",    int'(done),    int'(m_done));
      chk("running", int'(running), (m_owner >= 0) ? 1 : 0);
      chk("active",  int'(active),  m_active);
    end
    for (int i = 0; i < N; i++)
      if (done[i]) begin dlog_cyc.push_back(cyc); dlog_idx.push_back(i); end
    if (cyc >= w_lo && cyc <= w_hi && !busy[2]) b2_low++;
  end

  function automatic logic [N*W-1:0] sl(input int i, input int v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = W'(v);
    return r;
  endfunction

  // Drives ncyc cycles from a negedge: r1/l1 at k=0, r2/l2 at k=k2, strobe when k%per==per-1.
  task automatic run_seq(input int ncyc, input int per, input int k2,
                         input logic [N-1:0] r1, input logic [N*W-1:0] l1,
                         input logic [N-1:0] r2, input logic [N*W-1:0] l2);
    for (int k = 0; k < ncyc; k++) begin
      req    = (k == 0) ? r1 : ((k == k2) ? r2 : '0);
      len    = (k == 0) ? l1 : ((k == k2) ? l2 : '0);
      one_ms = (per > 0) && ((k % per) == per - 1);
      @(negedge clk);
    end
    req = '0; len = '0; one_ms = 1'b0;
  endtask

  int t0;

  initial begin
    rst_n = 1'b0; req = '0; len = '0; one_ms = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_running", int'(running), 0);
    chk("rst_active",  int'(active),  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, D=3, strobe every 10 cycles.
    dlog_cyc.delete(); dlog_idx.delete(); t0 = cyc;
    run_seq(40, 10, -1, 4'b0010, sl(1, 3), '0, '0);
    chk("single_cnt", dlog_cyc.size(), 1);
    if (dlog_cyc.size() == 1) begin
      chk("single_idx", dlog_idx[0], 1);
      chk("single_cyc", dlog_cyc[0] - t0, 31);
    end

    // Zero length: done three cycles after the request with no strobe at all.
    dlog_cyc.delete(); dlog_idx.delete(); t0 = cyc;
    run_seq(8, 0, -1, 4'b0001, sl(0, 0), '0, '0);
    chk("zero_cnt", dlog_cyc.size(), 1);
    if (dlog_cyc.size() == 1) chk("zero_cyc", dlog_cyc[0] - t0, 3);

    // Make 2 the last owner, then 0/2/3 together must be served 3, 0, 2.
    run_seq(8, 0, -1, 4'b0100, sl(2, 0), '0, '0);
    dlog_cyc.delete(); dlog_idx.delete();
    run_seq(40, 5, -1, 4'b1101, sl(0, 1) | sl(2, 1) | sl(3, 1), '0, '0);
    chk("rr_cnt", dlog_idx.size(), 3);
    if (dlog_idx.size() == 3) begin
      chk("rr_first",  dlog_idx[0], 3);
      chk("rr_second", dlog_idx[1], 0);
      chk("rr_third",  dlog_idx[2], 2);
    end

    // Duplicate while pending: first length (5) kept, single done.
    dlog_cyc.delete(); dlog_idx.delete(); t0 = cyc;
    run_seq(30, 4, 1, 4'b0010, sl(1, 5), 4'b0010, sl(1, 2));
    chk("dup_cnt", dlog_cyc.size(), 1);
    if (dlog_cyc.size() == 1) chk("dup_cyc", dlog_cyc[0] - t0, 21);

    // Re-request while own delay runs: two dones, busy[2] never drops between them.
    dlog_cyc.delete(); dlog_idx.delete(); t0 = cyc;
    w_lo = t0 + 1; w_hi = t0 + 13; b2_low = 0;
    run_seq(20, 4, 4, 4'b0100, sl(2, 2), 4'b0100, sl(2, 1));
    chk("rereq_cnt", dlog_cyc.size(), 2);
    if (dlog_cyc.size() == 2) begin
      chk("rereq_first",  dlog_cyc[0] - t0, 9);
      chk("rereq_second", dlog_cyc[1] - t0, 13);
    end
    chk("rereq_busy_gap", b2_low, 0);
    w_lo = -1; w_hi = -2;

    // Reset while counting (ctr=4) with 1 and 3 pending: everything clears, no done later.
    dlog_cyc.delete(); dlog_idx.delete();
    run_seq(6, 2, 1, 4'b0001, sl(0, 6), 4'b1010, sl(1, 3) | sl(3, 3));
    chk("pre_rst_busy",    int'(busy),    4'b1011);
    chk("pre_rst_running", int'(running), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    int'(busy),    0);
    chk("mid_rst_done",    int'(done),    0);
    chk("mid_rst_running", int'(running), 0);
    chk("mid_rst_active",  int'(active),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(30, 2, -1, '0, '0, '0, '0);
    chk("post_rst_dones", dlog_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
